// File: rtl/serial_word_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_packer_pkg
// Brief    : Shared types and constants for the serial word packer.
// Revision : 1.0 - initial release
// ============================================================================
package serial_word_packer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 8;

endpackage : serial_word_packer_pkg
`default_nettype wire

// File: rtl/serial_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_packer
// Brief    : Deserialises a framed MSB-first bit stream into words with
//            optional even parity; accepted words pulse wr toward the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_packer
    import serial_word_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  sof,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  wr,
    output logic                  busy,
    output logic                  parity_err,
    output logic                  frame_abort,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DATA_WIDTH - 1);

    state_t                r_state,     w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shreg,     w_shreg_nxt;
    logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_dout,      w_dout_nxt;
    logic                  r_wr,        w_wr_nxt;
    logic                  r_perr,      w_perr_nxt;
    logic                  r_abort,     w_abort_nxt;
    logic [ERR_CNT_W-1:0]  r_err_cnt,   w_err_cnt_nxt;

    logic [DATA_WIDTH-1:0] w_shift;
    logic                  w_parity;

    assign w_shift  = {r_shreg[DATA_WIDTH-2:0], bit_in};
    assign w_parity = (^r_shreg) ^ bit_in;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_dout    <= '0;
            r_wr      <= 1'b0;
            r_perr    <= 1'b0;
            r_abort   <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dout    <= w_dout_nxt;
            r_wr      <= w_wr_nxt;
            r_perr    <= w_perr_nxt;
            r_abort   <= w_abort_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_cnt_nxt     = r_cnt;
        w_dout_nxt    = r_dout;
        w_wr_nxt      = 1'b0;
        w_perr_nxt    = 1'b0;
        w_abort_nxt   = 1'b0;
        w_err_cnt_nxt = r_err_cnt;

        if (bit_valid) begin
            // sof always restarts; outside IDLE it also abandons the current word
            if (sof) begin
                w_abort_nxt = (r_state != IDLE);
                w_shreg_nxt = w_shift;
                w_cnt_nxt   = CNT_W'(1);
                w_state_nxt = DATA;
            end else begin
                case (r_state)
                    IDLE: ;
                    DATA: begin
                        w_shreg_nxt = w_shift;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        if (r_cnt == c_last_cnt) begin
                            if (PARITY_EN != 0) begin
                                w_state_nxt = PARITY;
                            end else begin
                                w_dout_nxt  = w_shift;
                                w_wr_nxt    = 1'b1;
                                w_state_nxt = IDLE;
                            end
                        end
                    end
                    PARITY: begin
                        if (!w_parity) begin
                            w_dout_nxt = r_shreg;
                            w_wr_nxt   = 1'b1;
                        end else begin
                            w_perr_nxt = 1'b1;
                            if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
                                w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
                            end
                        end
                        w_state_nxt = IDLE;
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    assign dout        = r_dout;
    assign wr          = r_wr;
    assign busy        = (r_state != IDLE);
    assign parity_err  = r_perr;
    assign frame_abort = r_abort;
    assign err_cnt     = r_err_cnt;

endmodule : serial_word_packer
`default_nettype wire

// File: tb/tb_serial_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_packer
// Brief    : Directed self-checking bench; one instance with parity, one without.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_packer;

    logic       clk;
    logic       resetn;

    logic       p_bit, p_valid, p_sof;
    logic [7:0] p_dout;
    logic       p_wr, p_busy, p_perr, p_abort;
    logic [7:0] p_err_cnt;

    logic       n_bit, n_valid, n_sof;
    logic [7:0] n_dout;
    logic       n_wr, n_busy, n_perr, n_abort;
    logic [7:0] n_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int p_wr_seen = 0;
    int base;

    serial_word_packer #(.DATA_WIDTH(8), .PARITY_EN(1)) u_dut_p (
        .clk(clk), .resetn(resetn), .bit_in(p_bit), .bit_valid(p_valid), .sof(p_sof),
        .dout(p_dout), .wr(p_wr), .busy(p_busy), .parity_err(p_perr),
        .frame_abort(p_abort), .err_cnt(p_err_cnt)
    );

    serial_word_packer #(.DATA_WIDTH(8), .PARITY_EN(0)) u_dut_n (
        .clk(clk), .resetn(resetn), .bit_in(n_bit), .bit_valid(n_valid), .sof(n_sof),
        .dout(n_dout), .wr(n_wr), .busy(n_busy), .parity_err(n_perr),
        .frame_abort(n_abort), .err_cnt(n_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (p_wr === 1'b1) p_wr_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p_drive(input logic s, input logic b);
        p_valid = 1'b1; p_sof = s; p_bit = b;
        tick();
        p_valid = 1'b0; p_sof = 1'b0;
    endtask

    task automatic p_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) p_drive(i == 7, w[i]);
    endtask

    task automatic n_drive(input logic s, input logic b);
        n_valid = 1'b1; n_sof = s; n_bit = b;
        tick();
        n_valid = 1'b0; n_sof = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        p_bit = 1'b0; p_valid = 1'b0; p_sof = 1'b0;
        n_bit = 1'b0; n_valid = 1'b0; n_sof = 1'b0;
        tick(); tick();
        resetn = 1'b1;

        // reset state
        check("rst_p_dout", p_dout, 0);
        check("rst_p_wr", p_wr, 0);
        check("rst_p_busy", p_busy, 0);
        check("rst_p_perr", p_perr, 0);
        check("rst_p_abort", p_abort, 0);
        check("rst_p_errcnt", p_err_cnt, 0);
        check("rst_n_dout", n_dout, 0);
        check("rst_n_busy", n_busy, 0);

        // bits without sof in IDLE are ignored
        p_drive(1'b0, 1'b1); p_drive(1'b0, 1'b0); p_drive(1'b0, 1'b1);
        check("idle_ignore_busy", p_busy, 0);

        // word accept 0xA5, parity 0
        p_drive(1'b1, 1'b1);
        check("a5_busy_rise", p_busy, 1);
        for (int i = 6; i >= 0; i--) p_drive(1'b0, (i == 5 || i == 2 || i == 0));
        check("a5_no_wr_before_parity", p_wr, 0);
        check("a5_busy_in_parity", p_busy, 1);
        p_drive(1'b0, 1'b0);
        check("a5_wr", p_wr, 1);
        check("a5_dout", p_dout, 8'hA5);
        check("a5_busy_fall", p_busy, 0);
        check("a5_errcnt", p_err_cnt, 0);
        tick();
        check("a5_wr_one_cycle", p_wr, 0);
        check("a5_dout_hold", p_dout, 8'hA5);

        // parity failure on the same frame
        p_word(8'hA5); p_drive(1'b0, 1'b1);
        check("pf1_perr", p_perr, 1);
        check("pf1_wr", p_wr, 0);
        check("pf1_dout", p_dout, 8'hA5);
        check("pf1_errcnt", p_err_cnt, 1);
        tick();
        check("pf1_perr_one_cycle", p_perr, 0);
        p_word(8'h01); p_drive(1'b0, 1'b0);
        check("pf2_perr", p_perr, 1);
        check("pf2_dout_kept", p_dout, 8'hA5);
        check("pf2_errcnt", p_err_cnt, 2);

        // mid-frame restart with a new 0x3C frame
        base = p_wr_seen;
        p_drive(1'b1, 1'b1); p_drive(1'b0, 1'b1); p_drive(1'b0, 1'b1); p_drive(1'b0, 1'b1);
        p_drive(1'b1, 1'b0);
        check("rs_abort", p_abort, 1);
        check("rs_no_wr", p_wr, 0);
        check("rs_busy", p_busy, 1);
        p_drive(1'b0, 1'b0);
        check("rs_abort_one_cycle", p_abort, 0);
        p_drive(1'b0, 1'b1); p_drive(1'b0, 1'b1); p_drive(1'b0, 1'b1);
        p_drive(1'b0, 1'b1); p_drive(1'b0, 1'b0); p_drive(1'b0, 1'b0);
        p_drive(1'b0, 1'b0);
        check("rs_wr", p_wr, 1);
        check("rs_dout", p_dout, 8'h3C);
        tick();
        check("rs_single_wr", p_wr_seen - base, 1);

        // stalls inside a 0x81 frame; sof/bit toggle while invalid must be ignored
        base = p_wr_seen;
        for (int i = 7; i >= -1; i--) begin
            repeat ($urandom_range(1, 3)) begin
                p_sof = 1'($urandom_range(0, 1));
                p_bit = 1'($urandom_range(0, 1));
                tick();
            end
            if (i >= 0) p_drive(i == 7, (i == 7 || i == 0));
            else        p_drive(1'b0, 1'b0);
        end
        check("stall_wr", p_wr, 1);
        check("stall_dout", p_dout, 8'h81);
        tick();
        check("stall_single_wr", p_wr_seen - base, 1);

        // error counter saturation: 260 forced parity errors on top of 2
        for (int k = 0; k < 252; k++) begin p_word(8'h00); p_drive(1'b0, 1'b1); end
        check("sat_errcnt_fe", p_err_cnt, 8'hFE);
        p_word(8'h00); p_drive(1'b0, 1'b1);
        check("sat_errcnt_ff", p_err_cnt, 8'hFF);
        for (int k = 0; k < 7; k++) begin p_word(8'h00); p_drive(1'b0, 1'b1); end
        check("sat_errcnt_hold", p_err_cnt, 8'hFF);
        check("sat_perr_pulse", p_perr, 1);
        check("sat_dout_kept", p_dout, 8'h81);

        // no parity, back-to-back 0xFF then 0x00
        for (int i = 7; i >= 0; i--) n_drive(i == 7, 1'b1);
        check("np_ff_wr", n_wr, 1);
        check("np_ff_dout", n_dout, 8'hFF);
        check("np_ff_busy_fall", n_busy, 0);
        n_drive(1'b1, 1'b0);
        check("np_00_wr_low", n_wr, 0);
        check("np_00_busy", n_busy, 1);
        for (int i = 6; i >= 1; i--) n_drive(1'b0, 1'b0);
        check("np_00_no_early_wr", n_wr, 0);
        n_drive(1'b0, 1'b0);
        check("np_00_wr", n_wr, 1);
        check("np_00_dout", n_dout, 8'h00);
        check("np_perr", n_perr, 0);
        check("np_abort", n_abort, 0);
        check("np_errcnt", n_err_cnt, 0);

        // reset mid-frame has priority over a valid bit
        p_drive(1'b1, 1'b1); p_drive(1'b0, 1'b0); p_drive(1'b0, 1'b1);
        p_drive(1'b0, 1'b1); p_drive(1'b0, 1'b0);
        check("mr_busy_before", p_busy, 1);
        resetn = 1'b0;
        p_drive(1'b1, 1'b1);
        resetn = 1'b1;
        check("mr_busy", p_busy, 0);
        check("mr_dout", p_dout, 0);
        check("mr_errcnt", p_err_cnt, 0);
        check("mr_wr", p_wr, 0);
        check("mr_abort", p_abort, 0);
        p_word(8'h5A); p_drive(1'b0, 1'b0);
        check("mr_5a_wr", p_wr, 1);
        check("mr_5a_dout", p_dout, 8'h5A);
        check("mr_5a_perr", p_perr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_word_packer
`default_nettype wire
